// File: rtl/adder_4_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package adder_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_4_seq_ctrl_if.sv
// Request/result handshake bundle for adder_4_seq_ctrl.
interface adder_4_seq_ctrl_if #(
    parameter int WORDS = 4
);
    localparam int W = adder_seq_pkg::NIBBLE_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_ci;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_ci, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_co, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ci, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_co, out_ovf
    );

endinterface

// File: rtl/adder_4_seq_ctrl_adder.sv
// Combinational 4-bit adder with carry in and carry out.
module adder_4_assign (
    output logic       co,
    output logic [3:0] sum,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/adder_4_seq_ctrl.sv
// Nibble-serial W-bit adder: one 4-bit adder reused over WORDS cycles, LSB nibble first.
// Optional subtraction is enabled by defining ADDER_4_SEQ_CTRL_SUB_EN.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready = 1
// RUN   | one nibble added per clock, idx selects the nibble
// DONE  | result presented, out_valid = 1 until out_ready
module adder_4_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic            clk,
    input  logic            rst,
    adder_4_seq_ctrl_if.slave bus
);

    localparam int W     = NIBBLE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_t state;
    state_t state_nxt;

    logic                idle;
    logic                done;
    logic                accept;
    logic                last;
    logic                sub_sel;
    logic                carry_init;

    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [W-1:0]        sum_q;
    logic                carry_q;
    logic                co_q;
    logic                ovf_q;
    logic                sub_q;
    logic [IDX_W-1:0]    idx;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] add_sum;
    logic                add_co;

`ifdef ADDER_4_SEQ_CTRL_SUB_EN
    assign sub_sel = bus.in_sub;
`else
    logic unused_sub;
    assign unused_sub = bus.in_sub;
    assign sub_sel    = 1'b0;
`endif

    // Subtraction is a + ~b + 1, so in_ci is ignored when subtracting.
    assign carry_init = sub_sel ? 1'b1 : bus.in_ci;
    assign accept     = bus.in_valid && idle;
    assign last       = (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (last)         state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idle = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:    idle = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign a_nib = a_q[int'(idx) * NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[int'(idx) * NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};

    adder_4_assign u_adder (
        .co  (add_co),
        .sum (add_sum),
        .a   (a_nib),
        .b   (b_nib),
        .ci  (carry_q)
    );

    // idx stops at the last nibble instead of wrapping; DONE never reads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            sub_q   <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            carry_q <= carry_init;
            sub_q   <= sub_sel;
            idx     <= '0;
        end else if (state == RUN) begin
            sum_q[int'(idx) * NIBBLE_W +: NIBBLE_W] <= add_sum;
            carry_q <= add_co;
            if (last) begin
                co_q  <= add_co;
                // carry into the MSB recovered as a ^ b ^ sum at bit W-1
                ovf_q <= a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1]
                       ^ add_sum[NIBBLE_W-1] ^ add_co;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready  = idle;
    assign bus.out_valid = done;
    assign bus.out_sum   = sum_q;
    assign bus.out_co    = co_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_4_seq_ctrl.sv
// Scoreboard bench for adder_4_seq_ctrl at WORDS = 4.
module tb_adder_4_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adder_4_seq_ctrl_if #(.WORDS(WORDS)) bus ();

    adder_4_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=0x%0h required=none", bus.out_sum);
                end else begin
                    e = sb_q.pop_front();
                    check("out_sum", 32'(bus.out_sum), 32'(e.sum));
                    check("out_co",  32'(bus.out_co),  32'(e.co));
                    check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub,
                          input logic [W-1:0] exp_sum, input logic exp_co,
                          input logic exp_ovf, input int stall);
        int   n;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("in_ready_wait", 32'(ok), 32'd1);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_ci     = ci;
        bus.in_sub    = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(posedge clk); #1;
        sb_q.push_back('{sum: exp_sum, co: exp_co, ovf: exp_ovf});
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_ci    = ~ci;
        bus.in_sub   = ~sub;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(WORDS));
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_sum",   32'(bus.out_sum),   32'(exp_sum));
            check("stall_ready", 32'(bus.in_ready),  32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("back_to_idle_ready", 32'(bus.in_ready),  32'd1);
        check("back_to_idle_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic reset_mid_run();
        bus.in_a     = 16'h1234;
        bus.in_b     = 16'h1111;
        bus.in_ci    = 1'b0;
        bus.in_sub   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_run_ready", 32'(bus.in_ready),  32'd1);
        check("rst_run_valid", 32'(bus.out_valid), 32'd0);
        check("rst_run_sum",   32'(bus.out_sum),   32'd0);
        check("rst_run_co",    32'(bus.out_co),    32'd0);
        check("rst_run_ovf",   32'(bus.out_ovf),   32'd0);
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_ci     = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ready", 32'(bus.in_ready),  32'd1);
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_sum",   32'(bus.out_sum),   32'd0);
        check("reset_co",    32'(bus.out_co),    32'd0);
        check("reset_ovf",   32'(bus.out_ovf),   32'd0);

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 0);
        run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 5);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        reset_mid_run();
`ifdef ADDER_4_SEQ_CTRL_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 0);
`else
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0, 0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 0);
`endif
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_4_seq_ctrl.md
ADDER_4_SEQ_CTRL -- requirements
Module: adder_4_seq_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 4: the operand width in 4-bit nibbles, legal range 2..8; W = 4*WORDS.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the requester presents an operation.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-006 SHALL have ports in_a and in_b, input, W bits each: the operands.
REQ-007 SHALL have port in_ci, input, 1 bit: the carry-in for nibble 0.
REQ-008 SHALL have port in_sub, input, 1 bit: subtract request, used only under REQ-025.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port out_sum, output, W bits: the result.
REQ-012 SHALL have ports out_co, output, 1 bit, the final carry-out, and out_ovf, output, 1 bit, two's-complement overflow.

Function
REQ-013 SHALL compute the W-bit sum with exactly one 4-bit adder, processing one nibble per clock, LSB nibble first.
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE -> RUN on in_valid && in_ready.
- RUN -> DONE after nibble WORDS-1 is registered.
- DONE -> IDLE on out_ready.
REQ-015 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-016 SHALL, on the accept edge, register in_a, in_b and the initial carry, and clear the nibble index to 0.
REQ-017 SHALL, on each RUN edge:
- write the adder sum for nibble idx into out_sum[4*idx+3:4*idx];
- set carry <= adder co;
- set idx <= idx+1.
REQ-018 SHALL assert out_valid exactly WORDS cycles after the accept edge.
- Throughput: one operation per WORDS+2 cycles minimum.
REQ-019 SHALL set out_co = carry-out of the top nibble.
REQ-020 SHALL set out_ovf = (carry into bit W-1) XOR out_co.
REQ-021 SHALL hold out_sum, out_co and out_ovf stable while out_valid && !out_ready.
REQ-022 SHALL ignore in_valid and operand changes outside IDLE; there is no queuing.
REQ-023 SHALL size idx to clog2(WORDS) bits; it is compared against WORDS-1 and never wraps during RUN.

Reset
REQ-024 SHALL, when rst = 1 at a clock edge in any state, including mid-RUN and DONE:
- go to IDLE and discard the operation;
- clear out_valid, out_sum, out_co, out_ovf, idx and carry to 0;
- assert in_ready = 1 from the next cycle.

Configuration
REQ-025 SHALL, with ADDER_4_SEQ_CTRL_SUB_EN defined, perform subtraction when in_sub = 1 at accept:
- b nibbles are inverted into the adder;
- the initial carry is 1 and in_ci is ignored;
- out_co = 1 means no borrow.
REQ-026 SHALL, without ADDER_4_SEQ_CTRL_SUB_EN, keep the in_sub port but ignore it, and always add with in_ci.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE = 0, RUN = 1, DONE = 2) and NIBBLE_W = 4 in shared package adder_seq_pkg.
REQ-028 SHALL instantiate the existing combinational 4-bit adder adder_4_assign (co, sum, a, b, ci) as its only sub-module.

Verification (WORDS = 4)
REQ-029 SHALL check add with carry propagation: 0x00FF + 0x0001, ci = 0 -> out_sum 0x0100, co = 0, ovf = 0, out_valid exactly 4 cycles after accept.
REQ-030 SHALL check full carry chain: 0xFFFF + 0x0001, ci = 0 -> out_sum 0x0000, co = 1, ovf = 0.
REQ-031 SHALL check signed overflow: 0x7FFF + 0x0001 -> out_sum 0x8000, co = 0, ovf = 1.
REQ-032 SHALL check backpressure: out_ready = 0 for 5 cycles in DONE -> out_valid and out_sum held, in_ready = 0; out_ready = 1 -> IDLE next cycle.
REQ-033 SHALL check reset mid-RUN: rst = 1 at the second RUN cycle -> next cycle IDLE, in_ready = 1, out_valid = 0, out_sum = 0.
REQ-034 SHALL check subtraction, with SUB_EN: 0x0005 - 0x0007, in_sub = 1 -> out_sum 0xFFFE, co = 0; without SUB_EN the same stimulus with ci = 0 -> 0x000C.
